udp_prefetch_fifo_sc: RTL and testbench
=======================================

# udp_prefetch_fifo_sc

Single-clock, parametrised first-word-fall-through (prefetch) FIFO for the UDP datapath: buffers checksum and payload words between the packet builder and the checksum/transmit stages. Same valid/enable handshake as the team's prefetch FIFOs, extended with configurable read pipeline depth, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 32, word width (1..1152)
- DEPTH_WIDTH, 8, total capacity CAP = 2**DEPTH_WIDTH words (4..20)
- RD_PIPE, 1, read pipeline: 0 = storage read combinational into output register, 1 = registered storage read plus output register
- AF_LEVEL, CAP-4, almost_full asserted when level >= AF_LEVEL
- AE_LEVEL, 4, almost_empty asserted when level <= AE_LEVEL

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request; accepted only when wr_vld=1
- wr_data  in  DATA_WIDTH  write data
- wr_vld  out  1  space available (level < CAP)
- rd_en  in  1  consume head word; effective only when rd_vld=1
- rd_data  out  DATA_WIDTH  head word, valid when rd_vld=1
- rd_vld  out  1  head word present
- level  out  DEPTH_WIDTH+1  words accepted and not yet consumed
- almost_full  out  1  level >= AF_LEVEL
- almost_empty  out  1  level <= AE_LEVEL
- clr_err  in  1  clears sticky error flags
- overflow  out  1  sticky: wr_en seen while wr_vld=0
- underflow  out  1  sticky: rd_en seen while rd_vld=0

## Operation
- Accept = wr_en & wr_vld; consume = rd_en & rd_vld. Both may occur in the same cycle.
- level: +1 on accept only, -1 on consume only, unchanged on both or neither. Counts all words held, including words in flight to the output register.
- Prefetch: whenever the output register is empty, or is being consumed, and a word is in storage, the next word moves forward automatically; no rd_en needed to expose the head.
- Order strictly preserved; no word duplicated or lost across the storage-to-output boundary, including consume-and-refill in the same cycle.
- Rejected write (wr_en, wr_vld=0): data dropped, overflow set. Rejected read (rd_en, rd_vld=0): no state change, underflow set.
- clr_err clears both flags. If a new error occurs in the same cycle, the flag stays set.
- Pointers wrap modulo the storage depth. Full and empty are resolved from level, never from pointer equality alone.
- Reset mid-operation discards all contents immediately (asynchronous).

## Timing
- Reset values: wr_vld=1, rd_vld=0, rd_data=0, level=0, almost_full=0 (AF_LEVEL>0), almost_empty=1, overflow=0, underflow=0.
- Write-to-visible latency into an empty FIFO: accepted at edge N, rd_vld=1 after edge N+1+RD_PIPE.
- Back-to-back reads: with continuous rd_en and enough data, one word per cycle and no bubbles after the first word appears.
- wr_vld, level, almost_full and almost_empty are registered and updated at the edge of the accept/consume. wr_vld deasserts the cycle after the accept that makes level = CAP.
- Full with rd_en and wr_en both high: the read is consumed, the write is rejected (wr_vld was 0), level becomes CAP-1, overflow is set.
- rd_vld may be 0 while level > 0 during the prefetch latency window.

## Structure
- Shared package udp_fifo_pkg: level/threshold width function (DEPTH_WIDTH+1), RD_PIPE encoding constants.
- Sub-module udp_prefetch_fifo_ram: simple dual-port storage (one write port, one read port), read registered when RD_PIPE=1, mapped to DRM.
- The top level holds pointers, level counter, prefetch/output register control, flags and thresholds.

## Test plan
- Reset then idle: wr_vld=1, rd_vld=0, level=0, almost_empty=1, no flags.
- Write 0x11111111 into an empty FIFO at edge N with RD_PIPE=1: rd_vld=1 with rd_data=0x11111111 after edge N+2; level=1 from edge N.
- DEPTH_WIDTH=4: write 16 incrementing words. wr_vld drops after the 16th; a 17th wr_en sets overflow and is dropped. Read all 16 back in order with no bubble; level returns to 0.
- Simultaneous wr_en/rd_en at level=5 for 100 cycles with random data: level stays 5 and the output sequence equals the input sequence delayed by 5 words.
- rd_en on an empty FIFO sets underflow. clr_err clears it; clr_err plus a new underflow in the same cycle keeps the flag set.
- Assert rst mid-burst at level 10: all outputs take reset values asynchronously; post-reset writes read back correctly and no stale words appear.

Source files
------------

// File: rtl/udp_fifo_pkg.sv
// Shared definitions for the UDP datapath FIFOs: read pipeline encodings
// and the width helper for level/threshold signals.
package udp_fifo_pkg;

  // Storage read feeds the output register combinationally
  localparam int RD_PIPE_COMB = 0;
  // Storage read is registered before the output register
  localparam int RD_PIPE_REG  = 1;

  // Level must represent 0..2**depth_width inclusive, hence one extra bit
  function automatic int level_width(input int depth_width);
    return depth_width + 1;
  endfunction

endpackage

// File: rtl/udp_prefetch_fifo_sc_if.sv
// Handshake bundle between the packet builder / checksum stages and the
// prefetch FIFO. The master side is the FIFO user, the slave side the FIFO.
interface udp_prefetch_fifo_sc_if
  import udp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 8
) ();

  logic                                wr_en;
  logic [DATA_WIDTH-1:0]               wr_data;
  logic                                wr_vld;
  logic                                rd_en;
  logic [DATA_WIDTH-1:0]               rd_data;
  logic                                rd_vld;
  logic [level_width(DEPTH_WIDTH)-1:0] level;
  logic                                almost_full;
  logic                                almost_empty;
  logic                                clr_err;
  logic                                overflow;
  logic                                underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  wr_vld, rd_data, rd_vld, level, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output wr_vld, rd_data, rd_vld, level, almost_full, almost_empty,
           overflow, underflow
  );

endinterface

// File: rtl/udp_prefetch_fifo_ram.sv
// Simple dual-port storage for the prefetch FIFO: one write port, one read
// port. With a registered read the output only advances on rd_en, so an
// unread word stays parked in the read register.
module udp_prefetch_fifo_ram
  import udp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_PIPE    = RD_PIPE_REG
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  // Write port; storage has no reset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  generate
    if (RD_PIPE == RD_PIPE_REG) begin : g_rd_reg
      logic [DATA_WIDTH-1:0] rd_q;

      // Registered read, only advanced when the controller issues a read
      always_ff @(posedge clk) begin
        if (rd_en) begin
          rd_q <= mem[rd_addr];
        end
      end

      assign rd_data = rd_q;
    end else begin : g_rd_comb
      assign rd_data = mem[rd_addr];
    end
  endgenerate

endmodule

// File: rtl/udp_prefetch_fifo_sc.sv
// Single-clock first-word-fall-through FIFO. Words flow storage -> optional
// read stage -> output register without needing rd_en; level counts every
// word held anywhere in that chain.
module udp_prefetch_fifo_sc
  import udp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 8,
  parameter int RD_PIPE     = RD_PIPE_REG,
  parameter int AF_LEVEL    = (2 ** DEPTH_WIDTH) - 4,
  parameter int AE_LEVEL    = 4
) (
  input logic                   clk,
  input logic                   rst,
  udp_prefetch_fifo_sc_if.slave bus
);

  localparam int LW = level_width(DEPTH_WIDTH);
  localparam logic [LW-1:0]          CAP_L   = LW'(2 ** DEPTH_WIDTH);
  localparam logic [LW-1:0]          AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0]          AE_L    = LW'(AE_LEVEL);
  localparam logic [LW-1:0]          LVL_ONE = LW'(1);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE = DEPTH_WIDTH'(1);

  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [LW-1:0]          mem_cnt;
  logic [LW-1:0]          level_q;
  logic [LW-1:0]          level_d;
  logic                   wr_vld_q;
  logic                   rd_vld_q;
  logic                   af_q;
  logic                   ae_q;
  logic                   ovf_q;
  logic                   unf_q;
  logic                   stage_vld;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [DATA_WIDTH-1:0]  ram_q;
  logic                   accept;
  logic                   consume;
  logic                   src_vld;
  logic                   out_load;
  logic                   issue;

  udp_prefetch_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(DEPTH_WIDTH),
    .RD_PIPE   (RD_PIPE)
  ) u_ram (
    .clk    (clk),
    .wr_en  (accept),
    .wr_addr(wr_ptr),
    .wr_data(bus.wr_data),
    .rd_en  (issue),
    .rd_addr(rd_ptr),
    .rd_data(ram_q)
  );

  // Handshake qualification and the prefetch chain: the output register
  // refills whenever it is empty or being drained, and the read stage
  // refills whenever it will be empty after this edge.
  always_comb begin
    accept   = bus.wr_en & wr_vld_q;
    consume  = bus.rd_en & rd_vld_q;
    src_vld  = (RD_PIPE == RD_PIPE_REG) ? stage_vld : (mem_cnt != '0);
    out_load = src_vld & (~rd_vld_q | consume);
    if (RD_PIPE == RD_PIPE_REG) begin
      issue = (mem_cnt != '0) & (~stage_vld | out_load);
    end else begin
      issue = out_load;
    end
  end

  // Next occupancy: a simultaneous accept and consume cancel out
  always_comb begin
    level_d = level_q;
    if (accept && !consume) begin
      level_d = level_q + LVL_ONE;
    end else if (!accept && consume) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // Storage pointers and count of words still sitting in storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (accept && !issue) begin
        mem_cnt <= mem_cnt + LVL_ONE;
      end else if (!accept && issue) begin
        mem_cnt <= mem_cnt - LVL_ONE;
      end
    end
  end

  // Read stage occupancy; only meaningful with a registered storage read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_vld <= 1'b0;
    end else if (RD_PIPE == RD_PIPE_REG) begin
      if (issue) begin
        stage_vld <= 1'b1;
      end else if (out_load) begin
        stage_vld <= 1'b0;
      end
    end else begin
      stage_vld <= 1'b0;
    end
  end

  // Output register holding the head word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      out_data <= '0;
    end else begin
      if (out_load) begin
        rd_vld_q <= 1'b1;
        out_data <= ram_q;
      end else if (consume) begin
        rd_vld_q <= 1'b0;
      end
    end
  end

  // Registered level, space-available and threshold flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q  <= '0;
      wr_vld_q <= 1'b1;
      af_q     <= (AF_L == '0);
      ae_q     <= 1'b1;
    end else begin
      level_q  <= level_d;
      wr_vld_q <= (level_d < CAP_L);
      af_q     <= (level_d >= AF_L);
      ae_q     <= (level_d <= AE_L);
    end
  end

  // Sticky error flags; a fresh error wins over a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~bus.clr_err) | (bus.wr_en & ~wr_vld_q);
      unf_q <= (unf_q & ~bus.clr_err) | (bus.rd_en & ~rd_vld_q);
    end
  end

  assign bus.wr_vld       = wr_vld_q;
  assign bus.rd_vld       = rd_vld_q;
  assign bus.rd_data      = out_data;
  assign bus.level        = level_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_udp_prefetch_fifo_sc.sv
// Directed bench for udp_prefetch_fifo_sc with a 16-word, registered-read
// configuration: latency, fill/drain, thresholds, sticky flags, steady
// streaming and asynchronous reset.
module tb_udp_prefetch_fifo_sc;

  localparam int DW  = 32;
  localparam int DPW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   check_count = 0;
  int   pass_count  = 0;
  logic [31:0] model_q [$];
  logic [31:0] rnd;

  udp_prefetch_fifo_sc_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(DPW)) bus ();

  udp_prefetch_fifo_sc #(
    .DATA_WIDTH (DW),
    .DEPTH_WIDTH(DPW),
    .RD_PIPE    (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end else begin
      pass_count++;
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] data,
                               input logic rd, input logic clr);
    bus.wr_en   = wr;
    bus.wr_data = data;
    bus.rd_en   = rd;
    bus.clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_wr_vld", bus.wr_vld, 1);
    checkOutput("rst_rd_vld", bus.rd_vld, 0);
    checkOutput("rst_rd_data", bus.rd_data, 0);
    checkOutput("rst_level", bus.level, 0);
    checkOutput("rst_af", bus.almost_full, 0);
    checkOutput("rst_ae", bus.almost_empty, 1);
    checkOutput("rst_ovf", bus.overflow, 0);
    checkOutput("rst_unf", bus.underflow, 0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;

    #12;
    checkResetValues();
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkResetValues();

    applyStimulus(1, 32'h1111_1111, 0, 0);
    checkOutput("lat_level_n", bus.level, 1);
    checkOutput("lat_vld_n", bus.rd_vld, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("lat_vld_n1", bus.rd_vld, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("lat_vld_n2", bus.rd_vld, 1);
    checkOutput("lat_data_n2", bus.rd_data, 32'h1111_1111);
    applyStimulus(0, 0, 1, 0);
    checkOutput("lat_level_rd", bus.level, 0);
    checkOutput("lat_vld_rd", bus.rd_vld, 0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 32'hA0 + i, 0, 0);
      checkOutput("fill_level", bus.level, i + 1);
      checkOutput("fill_wr_vld", bus.wr_vld, (i < 15));
      checkOutput("fill_af", bus.almost_full, ((i + 1) >= 12));
      checkOutput("fill_ae", bus.almost_empty, ((i + 1) <= 4));
    end
    applyStimulus(1, 32'hDEAD_BEEF, 0, 0);
    checkOutput("full_ovf", bus.overflow, 1);
    checkOutput("full_level", bus.level, 16);
    checkOutput("full_wr_vld", bus.wr_vld, 0);

    for (int i = 0; i < 16; i++) begin
      checkOutput("drain_vld", bus.rd_vld, 1);
      checkOutput("drain_data", bus.rd_data, 32'hA0 + i);
      applyStimulus(0, 0, 1, 0);
      checkOutput("drain_level", bus.level, 15 - i);
      checkOutput("drain_wr_vld", bus.wr_vld, 1);
    end
    checkOutput("drain_end_vld", bus.rd_vld, 0);
    checkOutput("drain_ovf_sticky", bus.overflow, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("clr_ovf", bus.overflow, 0);

    applyStimulus(0, 0, 1, 0);
    checkOutput("unf_set", bus.underflow, 1);
    checkOutput("unf_level", bus.level, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("unf_clr", bus.underflow, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("unf_set2", bus.underflow, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("unf_clr_and_set", bus.underflow, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("unf_clr2", bus.underflow, 0);

    for (int i = 0; i < 5; i++) begin
      rnd = $urandom;
      model_q.push_back(rnd);
      applyStimulus(1, rnd, 0, 0);
    end
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("steady_start_level", bus.level, 5);
    for (int i = 0; i < 100; i++) begin
      rnd = $urandom;
      model_q.push_back(rnd);
      checkOutput("steady_vld", bus.rd_vld, 1);
      checkOutput("steady_data", bus.rd_data, model_q.pop_front());
      applyStimulus(1, rnd, 1, 0);
      checkOutput("steady_level", bus.level, 5);
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("steady_tail_data", bus.rd_data, model_q.pop_front());
      applyStimulus(0, 0, 1, 0);
    end
    checkOutput("steady_end_level", bus.level, 0);
    checkOutput("steady_end_vld", bus.rd_vld, 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 32'hB0 + i, 0, 0);
    end
    checkOutput("burst_level", bus.level, 10);
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'hBB;
    rst = 1'b1;
    #1;
    checkResetValues();
    bus.wr_en = 1'b0;
    #2;
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'hC0 + i, 0, 0);
    end
    checkOutput("post_rst_level", bus.level, 3);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("post_rst_vld", bus.rd_vld, 1);
      checkOutput("post_rst_data", bus.rd_data, 32'hC0 + i);
      applyStimulus(0, 0, 1, 0);
    end
    checkOutput("post_rst_end_level", bus.level, 0);
    checkOutput("post_rst_end_vld", bus.rd_vld, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
